gnrl_skid_buf: RTL and testbench
================================

GNRL_SKID_BUF -- requirements
Module: gnrl_skid_buf

Interface
REQ-001 SHALL have parameter DW, default 32, meaning payload width in bits.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port i_vld  input  1  upstream payload valid.
REQ-005 SHALL have port i_rdy  output  1  buffer can accept upstream payload.
REQ-006 SHALL have port i_dat  input  DW  upstream payload.
REQ-007 SHALL have port o_vld  output  1  downstream payload valid.
REQ-008 SHALL have port o_rdy  input  1  downstream consumer accepts payload.
REQ-009 SHALL have port o_dat  output  DW  downstream payload.
REQ-010 SHALL have port stall_cnt  output  16  count of cycles with o_vld=1 and o_rdy=0; present only under GNRL_SKID_STALL_CNT_EN.

Function
REQ-011 SHALL be a two-entry valid/ready pipeline stage, with a main register driving o_dat and a skid register absorbing one beat.
REQ-012 SHALL transfer upstream when i_vld=1 and i_rdy=1 in the same cycle, and downstream when o_vld=1 and o_rdy=1 in the same cycle.
REQ-013 SHALL implement the FSM states EMPTY (0 beats), BUSY (main full) and FULL (main and skid full).
REQ-014 SHALL drive i_rdy from a register, equal to 1 exactly when the state is not FULL, with no combinational path from o_rdy.
REQ-015 SHALL drive o_vld=1 exactly when the state is not EMPTY, and o_dat from the main register with no combinational path from i_dat.
REQ-016 EMPTY: if i_vld=1, main<=i_dat and next state is BUSY; otherwise remain EMPTY.
REQ-017 BUSY: if i_vld=1 and o_rdy=1, main<=i_dat and remain BUSY; if i_vld=1 and o_rdy=0, skid<=i_dat and next state is FULL; if i_vld=0 and o_rdy=1, next state is EMPTY; otherwise hold.
REQ-018 FULL: if o_rdy=1, main<=skid and next state is BUSY; otherwise hold; i_vld is ignored because i_rdy=0.
REQ-019 SHALL have latency of exactly one cycle from upstream accept to o_vld=1 when EMPTY.
REQ-020 SHALL sustain throughput of one beat per cycle while o_rdy=1 continuously.
REQ-021 SHALL preserve beat order and never drop or duplicate a beat.
REQ-022 SHALL hold o_dat stable while o_vld=1 and o_rdy=0.
REQ-023 SHALL leave data registers un-reset; only the FSM state and the counter are reset.

Reset
REQ-024 SHALL, while reset=1, asynchronously force the state to EMPTY, giving i_rdy=1, o_vld=0 and stall_cnt=0.
REQ-025 SHALL discard buffered beats when reset is asserted mid-operation, with no output transfer in the reset cycle.
REQ-026 SHALL leave o_dat undefined after reset until the first load.

Configuration
REQ-027 SHALL, when macro GNRL_SKID_STALL_CNT_EN is defined, include port stall_cnt, incrementing by 1 per stall cycle and saturating at 16'hFFFF.
REQ-028 SHALL, when GNRL_SKID_STALL_CNT_EN is undefined, omit the stall_cnt port and counter logic, with dataflow behaviour identical to the defined case.

Structure
REQ-029 SHALL take FSM state encoding (2-bit, EMPTY=0, BUSY=1, FULL=2) and the stall counter width from the shared package.
REQ-030 SHALL instantiate sub-module sirv_gnrl_dffl twice (main and skid, DW wide) for data storage.
REQ-031 SHALL keep FSM and counter logic local to the module.

Verification
REQ-032 SHALL verify: reset, then one beat i_dat=32'hA5A5_0001 with o_rdy=1 -> o_vld=1 next cycle, o_dat=32'hA5A5_0001, then o_vld=0.
REQ-033 SHALL verify: stream 1..8 with o_rdy=1 -> outputs 1..8 on consecutive cycles, i_rdy constant 1.
REQ-034 SHALL verify: send 1,2 with o_rdy=0 -> state FULL, i_rdy=0, o_dat=1; raise o_rdy -> outputs 1 then 2, i_rdy returns to 1.
REQ-035 SHALL verify: hold o_rdy=0 for 5 cycles with o_vld=1 -> stall_cnt=5 (macro defined); ports absent when undefined.
REQ-036 SHALL verify: assert reset while FULL -> i_rdy=1 and o_vld=0 immediately, and a subsequent beat 32'h77 emerges alone.
REQ-037 SHALL verify random i_vld/o_rdy over 10k cycles against a scoreboard, with no loss, reorder or duplication.

Source files
------------

// File: rtl/gnrl_skid_buf_pkg.sv
// Shared types and constants for the skid buffer: FSM encoding and stall counter width.
// Used by gnrl_skid_buf; the counter helper is only referenced under GNRL_SKID_STALL_CNT_EN.
package gnrl_skid_buf_pkg;

   localparam int unsigned StallCntW = 16;

   typedef enum logic [1:0] {
      StEmpty = 2'd0,
      StBusy  = 2'd1,
      StFull  = 2'd2
   } skid_state_e;

   // Saturating increment; the counter sticks at all-ones instead of wrapping.
   function automatic logic [StallCntW-1:0] stall_sat_inc(input logic [StallCntW-1:0] v);
      return (&v) ? v : v + StallCntW'(1);
   endfunction

endpackage

// File: rtl/sirv_gnrl_dffl.sv
// Load-enabled D flip-flop bank without reset, used for un-reset payload storage.
module sirv_gnrl_dffl #(
   parameter int unsigned DW = 32
) (
   input  logic          clk,
   input  logic          lden,
   input  logic [DW-1:0] dnxt,
   output logic [DW-1:0] qout
);

   logic [DW-1:0] qout_q;

   always_ff @(posedge clk) begin
      if (lden) begin
         qout_q <= dnxt;
      end
   end

   assign qout = qout_q;

endmodule

// File: rtl/gnrl_skid_buf.sv
// Two-entry valid/ready skid buffer with registered i_rdy and o_dat (main + skid registers).
// Optional stall cycle counter port enabled by defining GNRL_SKID_STALL_CNT_EN.
module gnrl_skid_buf
   import gnrl_skid_buf_pkg::*;
#(
   parameter int unsigned DW = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 i_vld,
   output logic                 i_rdy,
   input  logic [DW-1:0]        i_dat,
   output logic                 o_vld,
   input  logic                 o_rdy,
`ifdef GNRL_SKID_STALL_CNT_EN
   output logic [StallCntW-1:0] stall_cnt,
`endif
   output logic [DW-1:0]        o_dat
);

   skid_state_e   state_q, state_d;
   logic          rdy_q;
   logic          main_ld, skid_ld, main_sel_skid;
   logic [DW-1:0] main_nxt, main_q, skid_q;

   // State register; i_rdy is registered from the next state so it never sees o_rdy combinationally.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StEmpty;
         rdy_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         rdy_q   <= (state_d != StFull);
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StEmpty: begin
            if (i_vld) state_d = StBusy;
         end
         StBusy: begin
            if (i_vld && !o_rdy)      state_d = StFull;
            else if (!i_vld && o_rdy) state_d = StEmpty;
         end
         StFull: begin
            if (o_rdy) state_d = StBusy;
         end
         default: state_d = StEmpty;
      endcase
   end

   always_comb begin
      main_ld       = 1'b0;
      skid_ld       = 1'b0;
      main_sel_skid = 1'b0;
      o_vld         = (state_q != StEmpty);
      unique case (state_q)
         StEmpty: begin
            main_ld = i_vld;
         end
         StBusy: begin
            main_ld = i_vld && o_rdy;
            skid_ld = i_vld && !o_rdy;
         end
         StFull: begin
            main_ld       = o_rdy;
            main_sel_skid = 1'b1;
         end
         default: ;
      endcase
   end

   assign i_rdy    = rdy_q;
   assign main_nxt = main_sel_skid ? skid_q : i_dat;
   assign o_dat    = main_q;

   sirv_gnrl_dffl #(
      .DW (DW)
   ) u_main (
      .clk  (clk),
      .lden (main_ld),
      .dnxt (main_nxt),
      .qout (main_q)
   );

   sirv_gnrl_dffl #(
      .DW (DW)
   ) u_skid (
      .clk  (clk),
      .lden (skid_ld),
      .dnxt (i_dat),
      .qout (skid_q)
   );

`ifdef GNRL_SKID_STALL_CNT_EN
   logic [StallCntW-1:0] stall_cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_q <= '0;
      end else if (o_vld && !o_rdy) begin
         stall_cnt_q <= stall_sat_inc(stall_cnt_q);
      end
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_gnrl_skid_buf.sv
// Self-checking bench for gnrl_skid_buf: directed scenarios plus a random scoreboard run.
module tb_gnrl_skid_buf;

   logic        clk;
   logic        reset;
   logic        i_vld;
   logic        i_rdy;
   logic [31:0] i_dat;
   logic        o_vld;
   logic        o_rdy;
   logic [31:0] o_dat;
`ifdef GNRL_SKID_STALL_CNT_EN
   logic [15:0] stall_cnt;
`endif

   gnrl_skid_buf #(
      .DW (32)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .i_vld     (i_vld),
      .i_rdy     (i_rdy),
      .i_dat     (i_dat),
      .o_vld     (o_vld),
      .o_rdy     (o_rdy),
`ifdef GNRL_SKID_STALL_CNT_EN
      .stall_cnt (stall_cnt),
`endif
      .o_dat     (o_dat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] sb[$];
   logic        in_fire, out_fire, stall_pre;
   logic [31:0] in_dat, out_dat, dat_pre, exp_dat;

   // Samples handshakes just before the edge, advances one cycle, settles #1 past the edge.
   task automatic tick();
      in_fire   = i_vld && i_rdy;
      out_fire  = o_vld && o_rdy;
      in_dat    = i_dat;
      out_dat   = o_dat;
      stall_pre = o_vld && !o_rdy;
      dat_pre   = o_dat;
      @(posedge clk);
      #1;
      if (in_fire) sb.push_back(in_dat);
   endtask

   task automatic test_reset();
      reset = 1'b1; i_vld = 1'b0; o_rdy = 1'b0; i_dat = '0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (i_rdy !== 1'b1) begin n_err++; $display("FAIL reset_i_rdy: got %b want 1", i_rdy); end
      n_cmp++;
      if (o_vld !== 1'b0) begin n_err++; $display("FAIL reset_o_vld: got %b want 0", o_vld); end
`ifdef GNRL_SKID_STALL_CNT_EN
      n_cmp++;
      if (stall_cnt !== 16'd0) begin
         n_err++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt);
      end
`endif
      reset = 1'b0;
      sb.delete();
   endtask

   task automatic test_single();
      o_rdy = 1'b1; i_vld = 1'b1; i_dat = 32'hA5A5_0001;
      tick();
      i_vld = 1'b0;
      n_cmp++;
      if (o_vld !== 1'b1) begin n_err++; $display("FAIL single_o_vld: got %b want 1", o_vld); end
      n_cmp++;
      if (o_dat !== 32'hA5A5_0001) begin
         n_err++; $display("FAIL single_o_dat: got %h want a5a50001", o_dat);
      end
      tick();
      n_cmp++;
      if (!out_fire || sb.size() == 0) begin
         n_err++; $display("FAIL single_xfer: fire %b queued %0d want fire 1", out_fire, sb.size());
      end else begin
         exp_dat = sb.pop_front();
         if (out_dat !== exp_dat) begin
            n_err++; $display("FAIL single_sb: got %h want %h", out_dat, exp_dat);
         end
      end
      n_cmp++;
      if (o_vld !== 1'b0) begin n_err++; $display("FAIL single_empty: got %b want 0", o_vld); end
   endtask

   task automatic test_stream();
      o_rdy = 1'b1;
      for (int c = 0; c < 9; c++) begin
         i_vld = (c < 8);
         i_dat = 32'(c + 1);
         if (c < 8) begin
            n_cmp++;
            if (i_rdy !== 1'b1) begin
               n_err++; $display("FAIL stream_i_rdy: cyc %0d got %b want 1", c, i_rdy);
            end
         end
         tick();
         if (c >= 1) begin
            n_cmp++;
            if (!out_fire || out_dat !== 32'(c)) begin
               n_err++;
               $display("FAIL stream_out: cyc %0d got fire %b dat %h want fire 1 dat %h",
                        c, out_fire, out_dat, 32'(c));
            end
            if (out_fire && sb.size() != 0) exp_dat = sb.pop_front();
         end
      end
      i_vld = 1'b0;
      n_cmp++;
      if (o_vld !== 1'b0 || sb.size() != 0) begin
         n_err++; $display("FAIL stream_drain: o_vld %b queued %0d want 0/0", o_vld, sb.size());
      end
   endtask

   task automatic test_full();
      o_rdy = 1'b0; i_vld = 1'b1; i_dat = 32'd1;
      tick();
      i_dat = 32'd2;
      tick();
      n_cmp++;
      if (i_rdy !== 1'b0) begin n_err++; $display("FAIL full_i_rdy: got %b want 0", i_rdy); end
      n_cmp++;
      if (o_vld !== 1'b1 || o_dat !== 32'd1) begin
         n_err++; $display("FAIL full_out: got vld %b dat %h want 1/1", o_vld, o_dat);
      end
      // Offered beat must be ignored while full.
      i_dat = 32'd3;
      tick();
      n_cmp++;
      if (in_fire || i_rdy !== 1'b0 || o_dat !== 32'd1) begin
         n_err++;
         $display("FAIL full_ignore: fire %b i_rdy %b dat %h want 0/0/1", in_fire, i_rdy, o_dat);
      end
      i_vld = 1'b0; o_rdy = 1'b1;
      for (int k = 1; k <= 2; k++) begin
         tick();
         n_cmp++;
         if (!out_fire || sb.size() == 0) begin
            n_err++; $display("FAIL full_drain%0d: fire %b want 1", k, out_fire);
         end else begin
            exp_dat = sb.pop_front();
            if (out_dat !== exp_dat || out_dat !== 32'(k)) begin
               n_err++; $display("FAIL full_drain%0d: got %h want %h", k, out_dat, 32'(k));
            end
         end
         n_cmp++;
         if (i_rdy !== 1'b1) begin
            n_err++; $display("FAIL full_rdy%0d: got %b want 1", k, i_rdy);
         end
      end
      n_cmp++;
      if (o_vld !== 1'b0) begin n_err++; $display("FAIL full_empty: got %b want 0", o_vld); end
   endtask

   task automatic test_stall();
`ifdef GNRL_SKID_STALL_CNT_EN
      reset = 1'b1;
      #1;
      reset = 1'b0;
      sb.delete();
      n_cmp++;
      if (stall_cnt !== 16'd0) begin
         n_err++; $display("FAIL stall_clr: got %0d want 0", stall_cnt);
      end
      o_rdy = 1'b0; i_vld = 1'b1; i_dat = 32'h55;
      tick();
      i_vld = 1'b0;
      repeat (5) tick();
      n_cmp++;
      if (stall_cnt !== 16'd5) begin
         n_err++; $display("FAIL stall_cnt: got %0d want 5", stall_cnt);
      end
      n_cmp++;
      if (o_dat !== 32'h55) begin n_err++; $display("FAIL stall_hold: got %h want 55", o_dat); end
      o_rdy = 1'b1;
      tick();
      if (out_fire && sb.size() != 0) exp_dat = sb.pop_front();
      n_cmp++;
      if (stall_cnt !== 16'd5 || !out_fire) begin
         n_err++; $display("FAIL stall_after: cnt %0d fire %b want 5/1", stall_cnt, out_fire);
      end
`endif
   endtask

   task automatic test_reset_full();
      int nbeats;
      nbeats = 0;
      o_rdy = 1'b0; i_vld = 1'b1; i_dat = 32'hAA;
      tick();
      i_dat = 32'hBB;
      tick();
      i_vld = 1'b0;
      n_cmp++;
      if (i_rdy !== 1'b0) begin n_err++; $display("FAIL rstfull_pre: got %b want 0", i_rdy); end
      reset = 1'b1;
      #1;
      n_cmp++;
      if (i_rdy !== 1'b1 || o_vld !== 1'b0) begin
         n_err++; $display("FAIL rstfull_async: i_rdy %b o_vld %b want 1/0", i_rdy, o_vld);
      end
      sb.delete();
      o_rdy = 1'b1;
      tick();
      n_cmp++;
      if (out_fire) begin n_err++; $display("FAIL rstfull_nofire: got 1 want 0"); end
      reset = 1'b0;
      i_vld = 1'b1; i_dat = 32'h77;
      tick();
      i_vld = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (out_fire) begin
            nbeats++;
            n_cmp++;
            if (sb.size() == 0) begin
               n_err++; $display("FAIL rstfull_extra: got %h want none", out_dat);
            end else begin
               exp_dat = sb.pop_front();
               if (out_dat !== exp_dat) begin
                  n_err++; $display("FAIL rstfull_dat: got %h want %h", out_dat, exp_dat);
               end
            end
         end
      end
      n_cmp++;
      if (nbeats != 1) begin n_err++; $display("FAIL rstfull_count: got %0d want 1", nbeats); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 10000; c++) begin
         i_vld = 1'($urandom_range(0, 1));
         i_dat = $urandom;
         o_rdy = 1'($urandom_range(0, 1));
         tick();
         if (out_fire) begin
            n_cmp++;
            if (sb.size() == 0) begin
               n_err++; $display("FAIL rand_dup: cyc %0d got %h want none", c, out_dat);
            end else begin
               exp_dat = sb.pop_front();
               if (out_dat !== exp_dat) begin
                  n_err++; $display("FAIL rand_order: cyc %0d got %h want %h", c, out_dat, exp_dat);
               end
            end
         end
         if (stall_pre) begin
            n_cmp++;
            if (o_vld !== 1'b1 || o_dat !== dat_pre) begin
               n_err++;
               $display("FAIL rand_hold: cyc %0d got vld %b dat %h want 1 %h", c, o_vld, o_dat, dat_pre);
            end
         end
      end
      i_vld = 1'b0; o_rdy = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (out_fire && sb.size() != 0) begin
            exp_dat = sb.pop_front();
            n_cmp++;
            if (out_dat !== exp_dat) begin
               n_err++; $display("FAIL rand_drain: got %h want %h", out_dat, exp_dat);
            end
         end
      end
      n_cmp++;
      if (sb.size() != 0 || o_vld !== 1'b0) begin
         n_err++; $display("FAIL rand_loss: queued %0d o_vld %b want 0/0", sb.size(), o_vld);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_single();
      test_stream();
      test_full();
      test_stall();
      test_reset_full();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
